darkroom_spi_receiver: RTL
==========================

# darkroom_spi_receiver

SPI slave that receives the lighthouse sensor frames sent by the DarkRoom SPI master. It oversamples SCK/SS_N/MOSI in the system clock domain, assembles 32-byte frames into 256-bit words (8 sensors × 32-bit combined data), and reports each frame's position within a burst. It sits on the receiving board, used for loopback verification and as the FPGA-side replacement for the ESP8266, and feeds a downstream sensor-data decoder.

## Interface
- NUMBER_OF_SPI_FRAMES, 1: frames per burst; frame_index_o wraps to 0 after this count.
- BURST_GAP_CYCLES, 4096: SS_N-high cycles after which the next frame is index 0.
- clock  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- sck_i  in  1  SPI clock, async to clock; idle low.
- ss_n_i  in  1  slave select, active low, async.
- mosi_i  in  1  serial data, async.
- frame_o  out  256  last good frame; byte n at bits [8n+7:8n].
- frame_index_o  out  4  burst index of frame_o.
- frame_valid_o  out  1  one-cycle pulse: frame_o/frame_index_o updated.
- frame_error_o  out  1  one-cycle pulse: frame discarded.
- busy_o  out  1  high while synchronized SS_N is low.
- error_count_o  out  8  discarded frames, saturating at 255.

## Operation
- Input sync: two flip-flops per input, then a third register for edge detection. The sync chain resets to idle: sck 0, ss_n 1, mosi 0.
- SPI mode 0: sample MOSI on SCK rising edge. Bytes arrive MSB first, 8 bits per byte.
- The first byte of a frame lands in frame bits [7:0]. Word k (sensor 8·frame + k) = bits [32k+31:32k].
- States:
  - IDLE: synced SS_N falling → RECEIVE; bit counter and byte counter cleared, shift buffer cleared.
  - RECEIVE: each SCK rise shifts one bit. At bit 8 the byte is written to its buffer slot and the byte counter increments (saturating at 33).
  - RECEIVE, SS_N rising:
    - If byte count is exactly 32 and the bit counter is 0 → DONE.
    - Otherwise → ERROR.
  - DONE (1 cycle): copy buffer to frame_o, load frame_index_o, pulse frame_valid_o, advance the index → IDLE.
  - ERROR (1 cycle): pulse frame_error_o, increment error_count_o (saturating). frame_o and index are unchanged → IDLE.
- Frame-index counter:
  - Advances only on good frames.
  - Wraps to 0 after index NUMBER_OF_SPI_FRAMES−1.
  - Forced to 0 when the gap counter (SS_N-high cycles since the last frame end) reaches BURST_GAP_CYCLES. The gap counter saturates there and clears on SS_N falling.
  - Erroneous frames do not advance the index; the burst realigns on the next gap.
- Simultaneous SCK rise and SS_N rise in the same synced cycle: SS_N wins and the bit is ignored.
- SCK edges while SS_N is high are ignored.
- Reset mid-frame: everything returns to reset values and the partial frame is dropped without an error pulse.

## Timing
- Reset values:
  - frame_o 0, frame_index_o 0, frame_valid_o 0, frame_error_o 0, busy_o 0, error_count_o 0.
  - State IDLE.
  - Gap counter saturated, so the first frame after reset is index 0.
- Input-to-internal-edge latency: 3 clocks.
- frame_valid_o / frame_error_o pulse 4 clocks after the SS_N_i rising pin edge.
- frame_o is stable from the valid pulse until the next valid pulse.
- busy_o follows synced SS_N with 2-clock latency.
- Requirement: SCK high time and low time ≥ 3 clocks each. MOSI must be stable around the SCK rise ±1 clock. SS_N high time ≥ 3 clocks.

## Test plan
- Single frame: send bytes 0x00..0x1F at an SCK period of 10 clocks → one frame_valid_o pulse; frame_o[31:0]=0x03020100; frame_o[255:224]=0x1F1E1D1C; index 0; no error.
- Burst, NUMBER_OF_SPI_FRAMES=2: two frames 1024 clocks apart, then a 5000-clock gap, then a third frame → indices 0, 1, 0.
- Short frame: SS_N rises after 20 bytes → frame_error_o pulse, error_count_o=1, frame_o unchanged. Next full frame is valid with index 0.
- Partial byte / long frame: 32 bytes + 3 bits, then 33 bytes → two error pulses, error_count_o=2.
- Async reset asserted at byte 10 of a frame, released, then a full frame sent → no error pulse; the valid frame has index 0.
- Saturation: 300 short frames → error_count_o stays at 255. SCK toggling with SS_N high → no outputs change.

Source files
------------

// File: rtl/darkroom_spi_receiver.sv
// SPI mode-0 slave for DarkRoom lighthouse frames: oversamples SCK/SS_N/MOSI in the
// system clock domain and assembles 32-byte frames into 256-bit words with a burst index.
module darkroom_spi_receiver #(
  parameter int NUMBER_OF_SPI_FRAMES = 1,
  parameter int BURST_GAP_CYCLES     = 4096
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         sck_i,
  input  logic         ss_n_i,
  input  logic         mosi_i,
  output logic [255:0] frame_o,
  output logic [3:0]   frame_index_o,
  output logic         frame_valid_o,
  output logic         frame_error_o,
  output logic         busy_o,
  output logic [7:0]   error_count_o
);

  localparam int GAP_W = $clog2(BURST_GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(BURST_GAP_CYCLES);
  localparam logic [3:0] LAST_INDEX = 4'(NUMBER_OF_SPI_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, RECEIVE, DONE, ERROR} state_t;

  state_t state, state_next;

  logic [2:0]       sck_sync;
  logic [2:0]       ss_sync;
  logic [1:0]       mosi_sync;
  logic             sck_rise, ss_fall, ss_rise, mosi_bit;
  logic             start_frame, shift_en, done_pulse, error_pulse;
  logic [2:0]       bit_cnt;
  logic [5:0]       byte_cnt;
  logic [7:0]       shift_reg;
  logic [255:0]     buffer;
  logic [3:0]       next_index;
  logic [GAP_W-1:0] gap_cnt;

  // Two synchronizer flops per input; the third sck/ss stage only serves edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync  <= 3'b000;
      ss_sync   <= 3'b111;
      mosi_sync <= 2'b00;
    end else begin
      sck_sync  <= {sck_sync[1:0], sck_i};
      ss_sync   <= {ss_sync[1:0], ss_n_i};
      mosi_sync <= {mosi_sync[0], mosi_i};
    end
  end

  assign sck_rise = sck_sync[1] & ~sck_sync[2];
  assign ss_fall  = ~ss_sync[1] & ss_sync[2];
  assign ss_rise  = ss_sync[1] & ~ss_sync[2];
  assign mosi_bit = mosi_sync[1];
  assign busy_o   = ~ss_sync[1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ss_fall) state_next = RECEIVE;
      RECEIVE: if (ss_rise) state_next = (byte_cnt == 6'd32 && bit_cnt == 3'd0) ? DONE : ERROR;
      DONE:    state_next = IDLE;
      ERROR:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A coincident SS_N rise masks the SCK rise so the trailing bit is dropped.
  always_comb begin
    start_frame = (state == IDLE) && ss_fall;
    shift_en    = (state == RECEIVE) && sck_rise && !ss_rise;
    done_pulse  = (state == DONE);
    error_pulse = (state == ERROR);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt   <= 3'd0;
      byte_cnt  <= 6'd0;
      shift_reg <= 8'd0;
      buffer    <= '0;
    end else if (start_frame) begin
      bit_cnt   <= 3'd0;
      byte_cnt  <= 6'd0;
      shift_reg <= 8'd0;
      buffer    <= '0;
    end else if (shift_en) begin
      shift_reg <= {shift_reg[6:0], mosi_bit};
      if (bit_cnt == 3'd7) begin
        bit_cnt <= 3'd0;
        if (byte_cnt < 6'd32) buffer[{byte_cnt[4:0], 3'b000} +: 8] <= {shift_reg[6:0], mosi_bit};
        if (byte_cnt < 6'd33) byte_cnt <= byte_cnt + 6'd1;
      end else begin
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  // Counts SS_N-high cycles; reaching the limit marks the start of a new burst.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                          gap_cnt <= GAP_MAX;
    else if (ss_fall)                      gap_cnt <= '0;
    else if (ss_sync[1] && gap_cnt != GAP_MAX) gap_cnt <= gap_cnt + GAP_W'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_o       <= '0;
      frame_index_o <= 4'd0;
      frame_valid_o <= 1'b0;
      frame_error_o <= 1'b0;
      error_count_o <= 8'd0;
      next_index    <= 4'd0;
    end else begin
      frame_valid_o <= done_pulse;
      frame_error_o <= error_pulse;
      if (done_pulse) begin
        frame_o       <= buffer;
        frame_index_o <= next_index;
        next_index    <= (next_index == LAST_INDEX) ? 4'd0 : next_index + 4'd1;
      end else if (gap_cnt == GAP_MAX) begin
        next_index <= 4'd0;
      end
      if (error_pulse && error_count_o != 8'hFF) error_count_o <= error_count_o + 8'd1;
    end
  end

endmodule
